// File: rtl/pcileech_activation_pkg.sv
// Shared types and default codes for the activation controller.
// The defaults match the stock pcileech unlock sequence.
package pcileech_activation_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MATCH   = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  localparam logic [63:0] DEF_UNLOCK_KEY   = {32'h52322313, 32'h49901330};
  localparam logic [31:0] DEF_CODE_LOCK    = 32'hF2F2D2D2;
  localparam logic [31:0] DEF_CODE_INT_EN  = 32'h5232231E;
  localparam logic [31:0] DEF_CODE_INT_DIS = 32'h5232231D;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pcileech_activation_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
// zero is combinational from the count register.
module pcileech_activation_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pcileech_activation_ctl.sv
// Snoops the com word stream for an unlock key sequence and control codes, gating
// byte enables while locked; repeated failures trigger a timed lockout.
module pcileech_activation_ctl
  import pcileech_activation_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SEQ_LEN        = 2,
  parameter logic [SEQ_LEN*DATA_WIDTH-1:0] UNLOCK_KEY = (SEQ_LEN*DATA_WIDTH)'(DEF_UNLOCK_KEY),
  parameter logic [DATA_WIDTH-1:0] CODE_LOCK    = DATA_WIDTH'(DEF_CODE_LOCK),
  parameter logic [DATA_WIDTH-1:0] CODE_INT_EN  = DATA_WIDTH'(DEF_CODE_INT_EN),
  parameter logic [DATA_WIDTH-1:0] CODE_INT_DIS = DATA_WIDTH'(DEF_CODE_INT_DIS),
  parameter bit RESET_ACTIVE   = 1'b1,
  parameter int WORD_TIMEOUT   = 256,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         din_valid,
  input  logic [DATA_WIDTH/8-1:0]      be_in,
  output logic [DATA_WIDTH/8-1:0]      be_out,
  output logic                         activation_passed,
  output logic                         int_enable,
  output logic                         locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int IDX_W = clog2_min1(SEQ_LEN);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam int TMO_W = clog2_min1(WORD_TIMEOUT);
  localparam int LCK_W = clog2_min1(LOCKOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
  // Timers fire on the cycle their count is already zero, hence the minus one.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WORD_TIMEOUT > 0 ? WORD_TIMEOUT - 1 : 0);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES > 0 ? LOCKOUT_CYCLES - 1 : 0);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              act_nxt, int_nxt, lock_nxt;
  logic [FC_W-1:0]   fc_nxt, fc_inc;
  logic [DATA_WIDTH-1:0] key_word;
  logic              tmo_load, tmo_dec, tmo_zero;
  logic              lck_load, lck_dec, lck_zero;
  logic              fail, unlock;

  assign key_word = UNLOCK_KEY[idx*DATA_WIDTH +: DATA_WIDTH];
  assign fc_inc   = fail_count + FC_W'(1);
  assign be_out   = activation_passed ? be_in : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      activation_passed <= RESET_ACTIVE;
      int_enable        <= 1'b0;
      locked_out        <= 1'b0;
      fail_count        <= '0;
    end else begin
      state             <= state_nxt;
      idx               <= idx_nxt;
      activation_passed <= act_nxt;
      int_enable        <= int_nxt;
      locked_out        <= lock_nxt;
      fail_count        <= fc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    act_nxt   = activation_passed;
    int_nxt   = int_enable;
    lock_nxt  = locked_out;
    fc_nxt    = fail_count;
    lck_load  = 1'b0;
    fail      = 1'b0;
    unlock    = 1'b0;
    tmo_load  = din_valid || (state != S_MATCH);
    tmo_dec   = (state == S_MATCH) && !din_valid;
    lck_dec   = (state == S_LOCKOUT);

    if (state == S_LOCKOUT) begin
      if (lck_zero) begin
        state_nxt = S_IDLE;
        lock_nxt  = 1'b0;
      end
      if (din_valid && (din == CODE_LOCK)) begin
        act_nxt = 1'b0;
        int_nxt = 1'b0;
      end
    end else if (din_valid) begin
      if (din == CODE_LOCK) begin
        act_nxt   = 1'b0;
        int_nxt   = 1'b0;
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end else if (din == CODE_INT_EN) begin
        if (activation_passed) int_nxt = 1'b1;
      end else if (din == CODE_INT_DIS) begin
        if (activation_passed) int_nxt = 1'b0;
      end else if (din == key_word) begin
        // idx stays 0 in S_IDLE, so the same compare serves the first word.
        if (idx == LAST_IDX) begin
          unlock = 1'b1;
        end else begin
          state_nxt = S_MATCH;
          idx_nxt   = idx + IDX_W'(1);
        end
      end else if (state == S_MATCH) begin
        fail = 1'b1;
      end
    end else if ((state == S_MATCH) && (WORD_TIMEOUT > 0) && tmo_zero) begin
      fail = 1'b1;
    end

    if (unlock) begin
      act_nxt   = 1'b1;
      fc_nxt    = '0;
      state_nxt = S_IDLE;
      idx_nxt   = '0;
    end

    if (fail) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      if (fc_inc == FC_W'(MAX_FAILS)) begin
        state_nxt = S_LOCKOUT;
        fc_nxt    = '0;
        lock_nxt  = 1'b1;
        lck_load  = 1'b1;
      end else begin
        fc_nxt = fc_inc;
      end
    end
  end

  pcileech_activation_timer #(.WIDTH(TMO_W)) u_word_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  pcileech_activation_timer #(.WIDTH(LCK_W)) u_lock_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lck_load),
    .load_val (LCK_LOAD),
    .dec      (lck_dec),
    .zero     (lck_zero)
  );

endmodule

// File: tb/tb_pcileech_activation_ctl.sv
// Directed and random stimulus against a cycle-level behavioural model of the
// activation controller, plus a 64-bit single-word-key instance.
module tb_pcileech_activation_ctl;

  localparam logic [31:0] K0   = 32'h49901330;
  localparam logic [31:0] K1   = 32'h52322313;
  localparam logic [31:0] LOCK = 32'hF2F2D2D2;
  localparam logic [31:0] IEN  = 32'h5232231E;
  localparam logic [31:0] IDIS = 32'h5232231D;
  localparam logic [31:0] BAD  = 32'h12345678;
  localparam logic [63:0] KEY64 = 64'hDEADBEEF_CAFEF00D;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [3:0]  be_in;
  logic [3:0]  be_out;
  logic        act, inten, locked;
  logic [1:0]  fc;

  logic [63:0] din2;
  logic        din_valid2;
  logic [7:0]  be_in2, be_out2;
  logic        act2, int2, locked2;
  logic [1:0]  fc2;

  pcileech_activation_ctl #(.RESET_ACTIVE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .be_in(be_in),
    .be_out(be_out), .activation_passed(act), .int_enable(inten),
    .locked_out(locked), .fail_count(fc)
  );

  pcileech_activation_ctl #(.DATA_WIDTH(64), .SEQ_LEN(1), .UNLOCK_KEY(KEY64)) u_dut64 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2), .be_in(be_in2),
    .be_out(be_out2), .activation_passed(act2), .int_enable(int2),
    .locked_out(locked2), .fail_count(fc2)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: matched-word progress, idle run length and remaining lockout cycles.
  int m_act, m_int, m_locked, m_fails, m_prog, m_idle, m_lrem;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] key_of(input int p);
    return (p == 0) ? K0 : K1;
  endfunction

  task automatic model_fail();
    m_prog = 0;
    m_idle = 0;
    m_fails++;
    if (m_fails == 3) begin
      m_fails  = 0;
      m_locked = 1;
      m_lrem   = 1024;
    end
  endtask

  task automatic model_step(input bit v, input logic [31:0] w, input bit r);
    if (r) begin
      m_act = 0; m_int = 0; m_locked = 0; m_fails = 0;
      m_prog = 0; m_idle = 0; m_lrem = 0;
    end else if (m_lrem > 0) begin
      if (v && w == LOCK) begin m_act = 0; m_int = 0; end
      m_lrem--;
      if (m_lrem == 0) m_locked = 0;
    end else if (v) begin
      m_idle = 0;
      if (w == LOCK) begin
        m_act = 0; m_int = 0; m_prog = 0;
      end else if (w == IEN) begin
        if (m_act != 0) m_int = 1;
      end else if (w == IDIS) begin
        if (m_act != 0) m_int = 0;
      end else if (w == key_of(m_prog)) begin
        m_prog++;
        if (m_prog == 2) begin m_act = 1; m_fails = 0; m_prog = 0; end
      end else if (m_prog > 0) begin
        model_fail();
      end
    end else if (m_prog > 0) begin
      m_idle++;
      if (m_idle == 256) model_fail();
    end
  endtask

  task automatic check_all();
    chk("act", act, m_act);
    chk("int_enable", inten, m_int);
    chk("locked_out", locked, m_locked);
    chk("fail_count", fc, m_fails);
    chk("be_out", be_out, (m_act != 0) ? be_in : 4'h0);
  endtask

  task automatic tick(input bit v, input logic [31:0] w);
    din_valid = v;
    din       = v ? w : 32'($urandom);
    be_in     = 4'($urandom);
    @(posedge clk);
    model_step(v, din, rst);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
  endtask

  task automatic tick2(input bit v, input logic [63:0] w, input logic [7:0] b);
    din_valid2 = v;
    din2       = w;
    be_in2     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; din = '0; din_valid = 1'b0; be_in = '0;
    din2 = '0; din_valid2 = 1'b0; be_in2 = 8'h3C;
    idle(2);
    rst = 1'b0;
    chk("rst_act", act, 0);
    chk("rst_fc", fc, 0);
    chk("rst_act64", act2, 1);
    chk("rst_be64", be_out2, 8'h3C);

    // Key sequence with a 10-cycle gap unlocks the cycle after the second word.
    tick(1, K0);
    idle(10);
    chk("pre_unlock", act, 0);
    tick(1, K1);
    chk("unlock_act", act, 1);
    be_in = 4'hF; #1;
    chk("be_full", be_out, 4'hF);

    tick(1, IEN);   chk("int_en", inten, 1);
    tick(1, IDIS);  chk("int_dis", inten, 0);
    tick(1, IEN);
    tick(1, LOCK);
    chk("lock_act", act, 0);
    chk("lock_int", inten, 0);
    chk("lock_be", be_out, 4'h0);
    tick(1, IEN);   chk("int_ign", inten, 0);

    // Three failed attempts, then a timed lockout.
    tick(1, K0); tick(1, BAD); chk("fail1", fc, 1);
    tick(1, K0); tick(1, BAD); chk("fail2", fc, 2);
    tick(1, K0); tick(1, BAD);
    chk("lockout", locked, 1);
    chk("lockout_fc", fc, 0);
    cnt = locked ? 1 : 0;
    tick(1, K0); if (locked) cnt++;
    tick(1, K1); if (locked) cnt++;
    chk("lock_ignore", act, 0);
    for (int i = 0; i < 1100 && locked; i++) begin
      tick(0, 32'h0);
      if (locked) cnt++;
    end
    chk("lockout_len", cnt, 1024);
    tick(1, K0); tick(1, K1);
    chk("post_lock_unlock", act, 1);

    // Inter-word timeout boundary.
    tick(1, LOCK);
    tick(1, K0); idle(256);
    chk("timeout_fail", fc, 1);
    tick(1, K1);
    chk("timeout_idle", act, 0);
    tick(1, K0); idle(255); tick(1, K1);
    chk("no_timeout", act, 1);
    chk("no_timeout_fc", fc, 0);

    // Reset mid-sequence.
    tick(1, IEN);
    chk("int_pre_rst", inten, 1);
    tick(1, K0);
    rst = 1'b1; tick(0, 32'h0); rst = 1'b0;
    chk("rst_seq_act", act, 0);
    chk("rst_seq_int", inten, 0);
    chk("rst_seq_lock", locked, 0);
    chk("rst_seq_fc", fc, 0);
    tick(1, K1);
    chk("no_residual", act, 0);

    // Reset mid-lockout.
    for (int i = 0; i < 3; i++) begin tick(1, K0); tick(1, BAD); end
    chk("lockout2", locked, 1);
    idle(5);
    rst = 1'b1; tick(0, 32'h0); rst = 1'b0;
    chk("rst_lock", locked, 0);
    tick(1, K0); tick(1, K1);
    chk("rst_lock_unlock", act, 1);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      int r, sel;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        idle($urandom_range(254, 257));
      end else if (r < 40) begin
        tick(0, 32'h0);
      end else begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1, 2: tick(1, K0);
          3, 4, 5: tick(1, K1);
          6:       tick(1, LOCK);
          7:       tick(1, IEN);
          8:       tick(1, IDIS);
          default: tick(1, 32'($urandom));
        endcase
      end
    end
    din_valid = 1'b0;

    // 64-bit instance with a single-word key.
    tick2(1, 64'h00000000_F2F2D2D2, 8'hFF);
    chk("w64_lock", act2, 0);
    chk("w64_lock_be", be_out2, 8'h00);
    tick2(1, 64'h1, 8'hFF);
    chk("w64_ignore", act2, 0);
    chk("w64_ignore_fc", fc2, 0);
    tick2(1, KEY64, 8'hA5);
    chk("w64_unlock", act2, 1);
    chk("w64_be", be_out2, 8'hA5);
    tick2(1, 64'h00000000_5232231E, 8'h5A);
    chk("w64_int", int2, 1);
    chk("w64_locked", locked2, 0);
    tick2(0, 64'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pcileech_activation_ctl.md
PCILEECH_ACTIVATION_CTL -- requirements
Module: pcileech_activation_ctl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: snooped word width; multiple of 8.
REQ-002 Parameter SEQ_LEN, default 2: number of words in the unlock sequence; range 1..8.
REQ-003 Parameter UNLOCK_KEY, default {32'h52322313, 32'h49901330}: packed SEQ_LEN*DATA_WIDTH; word k is the slice [k*DATA_WIDTH +: DATA_WIDTH]; word 0 arrives first.
REQ-004 Parameter CODE_LOCK, default 32'hF2F2D2D2: deactivation code.
REQ-005 Parameter CODE_INT_EN, default 32'h5232231E: interrupt enable code; CODE_INT_DIS, default 32'h5232231D: interrupt disable code.
REQ-006 Parameter RESET_ACTIVE, default 1: value of activation_passed after reset.
REQ-007 Parameter WORD_TIMEOUT, default 256: maximum idle cycles between sequence words; 0 disables the timeout.
REQ-008 Parameter MAX_FAILS, default 3: failed attempts that trigger lockout; LOCKOUT_CYCLES, default 1024: lockout duration.
REQ-009 clk  in  1  single clock; all logic is on its rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 din  in  DATA_WIDTH  snooped communication word.
REQ-012 din_valid  in  1  din is qualified this cycle.
REQ-013 be_in  in  DATA_WIDTH/8  byte enables from the com block.
REQ-014 be_out  out  DATA_WIDTH/8  gated byte enables.
REQ-015 activation_passed  out  1  device unlocked.
REQ-016 int_enable  out  1  interrupt generation permitted.
REQ-017 locked_out  out  1  lockout is in progress.
REQ-018 fail_count  out  $clog2(MAX_FAILS+1)  failed attempts since the last success or lockout.

Function
REQ-019 be_out = activation_passed ? be_in : 0. This is the only combinational path; all other outputs are registered.
REQ-020 FSM states are S_IDLE, S_MATCH (with index idx in 1..SEQ_LEN-1) and S_LOCKOUT. Only cycles with din_valid=1 are evaluated.
REQ-021 Decode priority per valid word is CODE_LOCK > CODE_INT_EN/CODE_INT_DIS > sequence.
REQ-022 CODE_LOCK, in any state: activation_passed <= 0, int_enable <= 0, FSM returns to S_IDLE. The lockout timer and fail_count are unchanged, and lockout continues if active.
REQ-023 CODE_INT_EN/CODE_INT_DIS set/clear int_enable, only while activation_passed=1 and not in S_LOCKOUT. In all other cases they are ignored. The FSM state is unchanged.
REQ-024 S_IDLE, word == key[0]: if SEQ_LEN=1, unlock; otherwise go to S_MATCH with idx=1. Other words are ignored and are not counted as failures.
REQ-025 S_MATCH, word == key[idx]: idx+1. A match at idx=SEQ_LEN-1 unlocks.
REQ-026 Unlock: activation_passed <= 1, fail_count <= 0, go to S_IDLE. Outputs change in the cycle after the final word (1-cycle latency).
REQ-027 S_MATCH, any other word: failure. The word is not re-evaluated as key[0].
REQ-028 S_MATCH timeout: when WORD_TIMEOUT>0 and WORD_TIMEOUT consecutive cycles pass without din_valid, this is a failure.
REQ-029 Failure handling: go to S_IDLE and fail_count+1. If the new count equals MAX_FAILS, go to S_LOCKOUT instead, with fail_count <= 0, locked_out <= 1, and the timer loaded with LOCKOUT_CYCLES.
REQ-030 A failure does not change activation_passed.
REQ-031 S_LOCKOUT: all words except CODE_LOCK are ignored. The timer decrements every cycle. When it reaches 0, locked_out <= 0 and the FSM goes to S_IDLE. Lockout therefore lasts exactly LOCKOUT_CYCLES cycles.
REQ-032 The timeout counter saturates and clears on every valid word and on every state entry.
REQ-033 din_valid=0 never changes state, except through the timeout in S_MATCH and the timer in S_LOCKOUT.

Reset
REQ-034 rst (synchronous, highest priority) sets: activation_passed=RESET_ACTIVE, int_enable=0, locked_out=0, fail_count=0, FSM=S_IDLE, idx=0, timers=0.
REQ-035 rst asserted mid-sequence or mid-lockout aborts it with no residual state.

Structure
REQ-036 Package pcileech_activation_pkg holds the state enum and the default code constants.
REQ-037 Sub-module pcileech_activation_timer: a loadable down-counter with a zero flag, instantiated once each for the timeout and the lockout.
REQ-038 The key word select is a parameter-indexed slice, not a ROM.

Verification
REQ-039 RESET_ACTIVE=0; din 49901330 then 52322313 (valid, gap of 10 cycles) -> activation_passed=1 in the cycle after the second word; be_in=F gives be_out=F.
REQ-040 Activated; CODE_LOCK -> activation_passed=0, int_enable=0, be_out=0 next cycle. Then CODE_INT_EN -> int_enable stays 0.
REQ-041 Three sequences as 49901330 then 12345678 -> fail_count 1, 2, then locked_out=1. A correct sequence during lockout is ignored. locked_out falls after exactly 1024 cycles, and a subsequent correct sequence unlocks.
REQ-042 49901330 followed by 256 idle cycles -> fail_count=1 and the FSM is in S_IDLE. With 255 idle cycles, the second word still unlocks.
REQ-043 Activated; CODE_INT_EN -> int_enable=1; CODE_INT_DIS -> 0. rst asserted at idx=1 -> all outputs return to their reset values the next cycle.
REQ-044 SEQ_LEN=1, DATA_WIDTH=64: a single matching key word -> unlock; be_out is 8 bits wide and gated correctly.
